// File: rtl/bus_arbiter_pkg.sv
// Shared system-bus constants: channel count, owner index width, master ids,
// arbiter state encoding and the default grant-hold limit.
package bus_arbiter_pkg;

   localparam int BUS_MASTER_CH = 4;
   localparam int BUS_OWNER_W   = 2;

   localparam logic [BUS_OWNER_W-1:0] BUS_MASTER_0 = 2'd0;
   localparam logic [BUS_OWNER_W-1:0] BUS_MASTER_1 = 2'd1;
   localparam logic [BUS_OWNER_W-1:0] BUS_MASTER_2 = 2'd2;
   localparam logic [BUS_OWNER_W-1:0] BUS_MASTER_3 = 2'd3;

   localparam int BUS_TIMEOUT_CYC_DEFAULT = 256;

   typedef enum logic {
      BUS_ARB_STATE_IDLE  = 1'b0,
      BUS_ARB_STATE_GRANT = 1'b1
   } bus_arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first active-high request found searching cyclically
// from start (rotate, priority-encode, un-rotate).
module bus_rr_pick
   import bus_arbiter_pkg::*;
#(
   parameter int N = BUS_MASTER_CH,
   parameter int W = BUS_OWNER_W
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         valid,
   output logic [W-1:0] idx
);

   logic [N-1:0] rot;
   logic [W-1:0] off;

   always_comb begin
      rot = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = req[(int'(start) + i) % N];
      end
      valid = |rot;
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = W'(i);
         end
      end
      idx = W'((int'(start) + int'(off)) % N);
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter with active-low request/grant and registered
// outputs. Optional grant-hold timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = BUS_MASTER_CH,
   parameter int OWNER_W     = BUS_OWNER_W,
   parameter int TIMEOUT_CYC = BUS_TIMEOUT_CYC_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] m_req_,
   output logic [NUM_MASTERS-1:0] m_grnt_,
   output logic [OWNER_W-1:0]     owner,
   output logic                   bus_busy,
   output logic                   timeout_err,
   output logic [OWNER_W-1:0]     timeout_owner
);

   localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_MASTERS - 1);

   bus_arb_state_e         state_q, state_d;
   logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
   logic [OWNER_W-1:0]     owner_q, owner_d;
   logic                   busy_q, busy_d;

   logic [NUM_MASTERS-1:0] req_raw, req_mask, pick_req, owner_bit;
   logic [OWNER_W-1:0]     pick_start, pick_idx;
   logic                   pick_valid, owner_req, timeout_hit, grant_new;

   assign req_raw    = ~m_req_;
   assign owner_bit  = NUM_MASTERS'(1) << owner_q;
   assign owner_req  = req_raw[owner_q];
   assign pick_start = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

   // The holder is never a candidate while it owns the bus, so a revoked
   // owner cannot win the re-arbitration that replaces it.
   assign pick_req = req_raw & ~req_mask &
                     ((state_q == BUS_ARB_STATE_GRANT) ? ~owner_bit : '1);

   bus_rr_pick #(
      .N (NUM_MASTERS),
      .W (OWNER_W)
   ) u_pick (
      .req   (pick_req),
      .start (pick_start),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      grnt_d    = grnt_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      grant_new = 1'b0;
      case (state_q)
         BUS_ARB_STATE_IDLE: begin
            if (pick_valid) begin
               grant_new = 1'b1;
            end
         end
         BUS_ARB_STATE_GRANT: begin
            if (!owner_req || timeout_hit) begin
               if (pick_valid) begin
                  grant_new = 1'b1;
               end else begin
                  state_d = BUS_ARB_STATE_IDLE;
                  grnt_d  = '1;
                  busy_d  = 1'b0;
               end
            end
         end
      endcase
      if (grant_new) begin
         state_d = BUS_ARB_STATE_GRANT;
         grnt_d  = ~(NUM_MASTERS'(1) << pick_idx);
         owner_d = pick_idx;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BUS_ARB_STATE_IDLE;
         grnt_q  <= '1;
         owner_q <= LAST_IDX;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grnt_q  <= grnt_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
      end
   end

   assign m_grnt_  = grnt_q;
   assign owner    = owner_q;
   assign bus_busy = busy_q;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] mask_q, mask_d;
   logic                   err_q, err_d;
   logic [OWNER_W-1:0]     tout_q, tout_d;

   assign timeout_hit = (state_q == BUS_ARB_STATE_GRANT) && owner_req &&
                        (cnt_q == CNT_MAX);
   assign req_mask    = mask_q;

   // A revoked master stays masked until its request line goes high once.
   always_comb begin
      cnt_d  = '0;
      mask_d = mask_q & req_raw;
      err_d  = 1'b0;
      tout_d = tout_q;
      if ((state_d == BUS_ARB_STATE_GRANT) && !grant_new) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (timeout_hit) begin
         mask_d[owner_q] = 1'b1;
         err_d           = 1'b1;
         tout_d          = owner_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         mask_q <= '0;
         err_q  <= 1'b0;
         tout_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         mask_q <= mask_d;
         err_q  <= err_d;
         tout_q <= tout_d;
      end
   end

   assign timeout_err   = err_q;
   assign timeout_owner = tout_q;
`else
   assign timeout_hit   = 1'b0;
   assign req_mask      = '0;
   assign timeout_err   = 1'b0;
   assign timeout_owner = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; the timeout scenario follows
// the BUS_ARB_TIMEOUT_EN build, otherwise indefinite hold is checked.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] m_req_;
   logic [3:0] m_grnt_;
   logic [1:0] owner;
   logic       bus_busy;
   logic       timeout_err;
   logic [1:0] timeout_owner;

   int checks   = 0;
   int failures = 0;

   bus_arbiter #(
      .NUM_MASTERS (4),
      .OWNER_W     (2),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .m_req_        (m_req_),
      .m_grnt_       (m_grnt_),
      .owner         (owner),
      .bus_busy      (bus_busy),
      .timeout_err   (timeout_err),
      .timeout_owner (timeout_owner)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      m_req_ = 4'b1111;
      step();
      step();
      checks++; if (m_grnt_ !== 4'b1111) begin failures++; $display("[TB] FAIL reset_grnt got=%b exp=1111", m_grnt_); end
      checks++; if (owner !== 2'd3) begin failures++; $display("[TB] FAIL reset_owner got=%0d exp=3", owner); end
      checks++; if (bus_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus_busy); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_terr got=%b exp=0", timeout_err); end
      checks++; if (timeout_owner !== 2'd0) begin failures++; $display("[TB] FAIL reset_towner got=%0d exp=0", timeout_owner); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      m_req_ = 4'b1110;
      #1;
      checks++; if (m_grnt_ !== 4'b1111) begin failures++; $display("[TB] FAIL single_no_comb got=%b exp=1111", m_grnt_); end
      step();
      checks++; if (m_grnt_ !== 4'b1110) begin failures++; $display("[TB] FAIL single_grnt got=%b exp=1110", m_grnt_); end
      checks++; if (owner !== BUS_MASTER_0) begin failures++; $display("[TB] FAIL single_owner got=%0d exp=0", owner); end
      checks++; if (bus_busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", bus_busy); end
   endtask

   task automatic test_contention();
      m_req_ = 4'b1111;
      step();
      checks++; if (m_grnt_ !== 4'b1111) begin failures++; $display("[TB] FAIL cont_idle got=%b exp=1111", m_grnt_); end
      checks++; if (owner !== 2'd0) begin failures++; $display("[TB] FAIL cont_idle_owner got=%0d exp=0", owner); end
      m_req_ = 4'b0101;
      step();
      checks++; if (m_grnt_ !== 4'b1101) begin failures++; $display("[TB] FAIL cont_m1 got=%b exp=1101", m_grnt_); end
      checks++; if (owner !== BUS_MASTER_1) begin failures++; $display("[TB] FAIL cont_m1_owner got=%0d exp=1", owner); end
      m_req_ = 4'b0111;
      step();
      checks++; if (m_grnt_ !== 4'b0111) begin failures++; $display("[TB] FAIL cont_m3 got=%b exp=0111", m_grnt_); end
      checks++; if (owner !== BUS_MASTER_3) begin failures++; $display("[TB] FAIL cont_m3_owner got=%0d exp=3", owner); end
      checks++; if (bus_busy !== 1'b1) begin failures++; $display("[TB] FAIL cont_m3_busy got=%b exp=1", bus_busy); end
   endtask

   task automatic test_idle_return();
      m_req_ = 4'b1111;
      step();
      checks++; if (m_grnt_ !== 4'b1111) begin failures++; $display("[TB] FAIL idle_grnt got=%b exp=1111", m_grnt_); end
      checks++; if (bus_busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b exp=0", bus_busy); end
      checks++; if (owner !== 2'd3) begin failures++; $display("[TB] FAIL idle_owner got=%0d exp=3", owner); end
      m_req_ = 4'b1011;
      step();
      checks++; if (m_grnt_ !== 4'b1011) begin failures++; $display("[TB] FAIL idle_m2 got=%b exp=1011", m_grnt_); end
      checks++; if (owner !== BUS_MASTER_2) begin failures++; $display("[TB] FAIL idle_m2_owner got=%0d exp=2", owner); end
   endtask

   task automatic test_reset_mid();
      m_req_ = 4'b1010;
      reset  = 1'b1;
      step();
      checks++; if (m_grnt_ !== 4'b1111) begin failures++; $display("[TB] FAIL rmid_grnt got=%b exp=1111", m_grnt_); end
      checks++; if (owner !== 2'd3) begin failures++; $display("[TB] FAIL rmid_owner got=%0d exp=3", owner); end
      checks++; if (bus_busy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_busy got=%b exp=0", bus_busy); end
      reset = 1'b0;
      step();
      checks++; if (m_grnt_ !== 4'b1110) begin failures++; $display("[TB] FAIL rmid_m0 got=%b exp=1110", m_grnt_); end
      checks++; if (owner !== 2'd0) begin failures++; $display("[TB] FAIL rmid_m0_owner got=%0d exp=0", owner); end
      m_req_ = 4'b1111;
      step();
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_g;
      int         e;
      pulse_reset();
      m_req_ = 4'b0000;
      step();
      for (int k = 0; k < 6; k++) begin
         e     = k % 4;
         exp_g = ~(4'b0001 << e);
         for (int h = 0; h < 3; h++) begin
            checks++; if (m_grnt_ !== exp_g) begin failures++; $display("[TB] FAIL rot_k%0d_h%0d got=%b exp=%b", k, h, m_grnt_, exp_g); end
            checks++; if ($countones(~m_grnt_) != 1) begin failures++; $display("[TB] FAIL rot_onehot_k%0d_h%0d got=%b exp=one low bit", k, h, m_grnt_); end
            if (h < 2) step();
         end
         m_req_    = 4'b0000;
         m_req_[e] = 1'b1;
         step();
         m_req_ = 4'b0000;
      end
      m_req_ = 4'b1111;
      step();
      step();
      checks++; if (bus_busy !== 1'b0) begin failures++; $display("[TB] FAIL rot_end_busy got=%b exp=0", bus_busy); end
      checks++; if (owner !== 2'd2) begin failures++; $display("[TB] FAIL rot_end_owner got=%0d exp=2", owner); end
   endtask

`ifdef BUS_ARB_TIMEOUT_EN
   task automatic test_timeout();
      pulse_reset();
      m_req_ = 4'b1001;
      step();
      for (int i = 0; i < 8; i++) begin
         checks++; if (m_grnt_ !== 4'b1101) begin failures++; $display("[TB] FAIL to_hold_%0d got=%b exp=1101", i, m_grnt_); end
         checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL to_early_err_%0d got=%b exp=0", i, timeout_err); end
         if (i < 7) step();
      end
      step();
      checks++; if (m_grnt_ !== 4'b1011) begin failures++; $display("[TB] FAIL to_handover got=%b exp=1011", m_grnt_); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL to_err got=%b exp=1", timeout_err); end
      checks++; if (timeout_owner !== 2'd1) begin failures++; $display("[TB] FAIL to_towner got=%0d exp=1", timeout_owner); end
      checks++; if (owner !== 2'd2) begin failures++; $display("[TB] FAIL to_owner got=%0d exp=2", owner); end
      step();
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL to_err_pulse got=%b exp=0", timeout_err); end
      checks++; if (timeout_owner !== 2'd1) begin failures++; $display("[TB] FAIL to_towner_hold got=%0d exp=1", timeout_owner); end
      m_req_ = 4'b1101;
      step();
      step();
      checks++; if (m_grnt_ !== 4'b1111) begin failures++; $display("[TB] FAIL to_masked got=%b exp=1111", m_grnt_); end
      m_req_ = 4'b1111;
      step();
      m_req_ = 4'b1101;
      step();
      checks++; if (m_grnt_ !== 4'b1101) begin failures++; $display("[TB] FAIL to_unmasked got=%b exp=1101", m_grnt_); end
      m_req_ = 4'b1111;
      step();
   endtask
`else
   task automatic test_hold();
      pulse_reset();
      m_req_ = 4'b1001;
      step();
      for (int i = 0; i < 20; i++) begin
         checks++; if (m_grnt_ !== 4'b1101) begin failures++; $display("[TB] FAIL hold_%0d got=%b exp=1101", i, m_grnt_); end
         checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL hold_err_%0d got=%b exp=0", i, timeout_err); end
         step();
      end
      m_req_ = 4'b1011;
      step();
      checks++; if (m_grnt_ !== 4'b1011) begin failures++; $display("[TB] FAIL hold_next got=%b exp=1011", m_grnt_); end
      checks++; if (timeout_owner !== 2'd0) begin failures++; $display("[TB] FAIL hold_towner got=%0d exp=0", timeout_owner); end
      m_req_ = 4'b1111;
      step();
   endtask
`endif

   initial begin
      reset  = 1'b1;
      m_req_ = 4'b1111;
      @(negedge clk);
      test_reset();
      test_single();
      test_contention();
      test_idle_return();
      test_reset_mid();
      test_back_to_back();
`ifdef BUS_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_hold();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
